// File: rtl/shared_reg_arbiter_if.sv
// ============================================================================
// shared_reg_arbiter_if : requester/arbiter bus for the shared register block
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface shared_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDXW    = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     op;
  logic [WIDTH*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic                     busy;
  logic [IDXW-1:0]          owner;
  logic [WIDTH-1:0]         q;
  logic [WIDTH-1:0]         q_n;

  modport master (
    output req, op, wdata,
    input  gnt, ack, busy, owner, q, q_n
  );

  modport slave (
    input  req, op, wdata,
    output gnt, ack, busy, owner, q, q_n
  );
endinterface

`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
// ============================================================================
// shared_reg_arbiter : round-robin arbiter that sequences commands into one
//                      shared register via a grant/commit/ack handshake
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shared_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDXW    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  state_t               state_q;
  logic [IDXW-1:0]      ptr_q;
  logic [IDXW-1:0]      owner_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [WIDTH-1:0]     q_q;

  logic [1:0]           op_a    [NUM_REQ];
  logic [WIDTH-1:0]     wdata_a [NUM_REQ];
  logic [IDXW-1:0]      win;
  logic                 win_vld;
  logic [IDXW-1:0]      idx_w;
  logic [WIDTH-1:0]     q_d;
  logic [IDXW-1:0]      ptr_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i]    = bus.op[2*i +: 2];
      wdata_a[i] = bus.wdata[WIDTH*i +: WIDTH];
    end
  end

  // Scan downward so the last hit is the first requester at or after ptr.
  always_comb begin
    int idx;
    idx     = 0;
    idx_w   = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = IDXW'(idx);
      if (bus.req[idx_w]) begin
        win_vld = 1'b1;
        win     = idx_w;
      end
    end
  end

  always_comb begin
    case (op_a[owner_q])
      OP_LOAD:  q_d = wdata_a[owner_q];
      OP_CLEAR: q_d = '0;
      OP_SET:   q_d = '1;
      default:  q_d = ~q_q;
    endcase
    ptr_d = (owner_q == IDXW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            gnt_q   <= NUM_REQ'(1) << win;
            owner_q <= win;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          gnt_q <= '0;
          // A requester that withdrew during its grant cycle forfeits the slot.
          if (bus.req[owner_q]) begin
            q_q     <= q_d;
            ack_q   <= NUM_REQ'(1) << owner_q;
            ptr_q   <= ptr_d;
            state_q <= ACK;
          end else begin
            state_q <= IDLE;
          end
        end
        ACK: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.owner = owner_q;
  assign bus.q     = q_q;
  assign bus.q_n   = ~q_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
// ============================================================================
// tb_shared_reg_arbiter : directed scoreboard bench for shared_reg_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shared_reg_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int IDXW    = 2;

  typedef struct {
    int         idx;
    logic [7:0] qv;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  shared_reg_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   gnt_cyc = 0;
  exp_t sb[$];
  logic [7:0] m_q   = 8'h00;
  int         m_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic expect_txn(input int w, input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    case (o)
      2'b00:   m_q = d;
      2'b01:   m_q = 8'h00;
      2'b10:   m_q = 8'hFF;
      default: m_q = ~m_q;
    endcase
    m_ptr = (w + 1) % NUM_REQ;
    e.idx = w;
    e.qv  = m_q;
    sb.push_back(e);
  endtask

  task automatic drive(input int i, input logic [1:0] o, input logic [7:0] d);
    bus.op[2*i +: 2]    = o;
    bus.wdata[8*i +: 8] = d;
  endtask

  // Waits (bounded) for a grant, then checks grant and the following ack cycle.
  task automatic serve();
    exp_t e;
    int n;
    logic [7:0] nq;
    n = 0;
    e = sb.pop_front();
    nq = ~e.qv;
    while (bus.gnt == '0 && n < 20) begin
      step();
      n++;
    end
    chk("gnt", bus.gnt, 32'(1) << e.idx);
    chk("owner", bus.owner, e.idx);
    chk("busy_grant", bus.busy, 1);
    gnt_cyc = cyc;
    step();
    chk("ack", bus.ack, 32'(1) << e.idx);
    chk("gnt_clear", bus.gnt, 0);
    chk("q", bus.q, e.qv);
    chk("q_n", bus.q_n, nq);
  endtask

  task automatic issue(input int i, input logic [1:0] o, input logic [7:0] d);
    int w;
    drive(i, o, d);
    bus.req = 4'(1) << i;
    w = pick(bus.req);
    expect_txn(w, o, d);
    serve();
    bus.req = '0;
    step();
    chk("ack_pulse_end", bus.ack, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int prev;
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;

    // Reset applied mid-cycle: outputs clear without waiting for an edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_q", bus.q, 8'h00);
    chk("rst_q_n", bus.q_n, 8'hFF);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_gnt", bus.gnt, 0);
      chk("idle_ack", bus.ack, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_q", bus.q, 8'h00);
    end

    // Single load from requester 2
    issue(2, 2'b00, 8'hA5);
    chk("owner_hold", bus.owner, 2);

    // Abort: requester 3 withdraws during its grant, requester 0 waits
    drive(3, 2'b00, 8'h11);
    drive(0, 2'b11, 8'h00);
    bus.req = 4'b1001;
    step();
    chk("abort_gnt", bus.gnt, 4'b1000);
    bus.req = 4'b0001;
    step();
    chk("abort_no_ack", bus.ack, 0);
    chk("abort_gnt_clr", bus.gnt, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_q", bus.q, m_q);
    w = pick(bus.req);
    expect_txn(w, 2'b11, 8'h00);
    serve();
    bus.req = '0;
    step();

    // Command sequence on requester 1
    issue(1, 2'b00, 8'h0F);
    issue(1, 2'b11, 8'h00);
    issue(1, 2'b01, 8'h00);
    issue(1, 2'b10, 8'h00);
    issue(3, 2'b00, 8'h3C);

    // Fairness under full contention
    for (int i = 0; i < NUM_REQ; i++) drive(i, 2'b10, 8'(8'h10 + i));
    bus.req = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      w = pick(4'b1111);
      expect_txn(w, 2'b10, 8'(8'h10 + w));
    end
    prev = 0;
    for (int t = 0; t < 12; t++) begin
      serve();
      if (t > 0) chk("grant_spacing", gnt_cyc - prev, 3);
      prev = gnt_cyc;
      if (t == 11) bus.req = '0;
      step();
    end

    issue(1, 2'b00, 8'h81);

    // Reset during GRANT abandons the transaction and restarts ptr at 0
    drive(3, 2'b00, 8'h77);
    drive(1, 2'b00, 8'h81);
    bus.req = 4'b1010;
    w = pick(bus.req);
    step();
    chk("pre_rst_gnt", bus.gnt, 32'(1) << w);
    #2 reset = 1'b1;
    #1;
    chk("midrst_gnt", bus.gnt, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_q", bus.q, 8'h00);
    chk("midrst_ack", bus.ack, 0);
    m_q   = 8'h00;
    m_ptr = 0;
    step();
    chk("rst_hold_ack", bus.ack, 0);
    chk("rst_hold_q", bus.q, 8'h00);
    #3 reset = 1'b0;
    w = pick(bus.req);
    expect_txn(w, 2'b00, 8'h81);
    serve();
    bus.req = '0;
    step();
    chk("final_ack", bus.ack, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
